// File: rtl/phys_reg_free_list.sv
// Physical-register free list for rename: circular buffer of free register numbers,
// self-populated after reset with every register above the architectural range.
module phys_reg_free_list #(
    parameter int unsigned ARCH_REG_NUM_WIDTH     = 5,
    parameter int unsigned PHYSICAL_REG_NUM_WIDTH = 7
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              alloc_req,
    output logic                              alloc_valid,
    output logic [PHYSICAL_REG_NUM_WIDTH-1:0] alloc_reg_num,
    input  logic                              commit_valid,
    input  logic                              commit_with_write,
    input  logic [PHYSICAL_REG_NUM_WIDTH-1:0] commited_wr_register,
    output logic [PHYSICAL_REG_NUM_WIDTH:0]   free_count,
    output logic                              init_done,
    output logic                              overflow_err
);

    localparam int unsigned DEPTH      = 2 ** PHYSICAL_REG_NUM_WIDTH;
    localparam int unsigned INIT_FIRST = 2 ** ARCH_REG_NUM_WIDTH;
    localparam int unsigned PW         = PHYSICAL_REG_NUM_WIDTH;

    localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(DEPTH);
    localparam logic [PW-1:0] FILL_FIRST = PW'(INIT_FIRST);
    localparam logic [PW-1:0] FILL_LAST  = PW'(DEPTH - 1);

    typedef enum logic {
        StInit,
        StReady
    } state_e;

    state_e        state_q;
    logic [PW-1:0] fill_ptr_q;
    logic [PW-1:0] head_ptr_q;
    logic [PW-1:0] tail_ptr_q;
    logic [PW:0]   count_q;
    logic          overflow_q;

    logic [PW-1:0] buffer [DEPTH];

    logic          grant;
    logic          push_req;
    logic          full;
    logic          push;
    logic          wr_en;
    logic [PW-1:0] wr_data;

    // Reset gates the grant so a mid-run reset never hands out a register.
    assign grant    = alloc_req && !reset && (state_q == StReady) && (count_q != '0);
    assign push_req = commit_valid && commit_with_write && (state_q == StReady) &&
                      (commited_wr_register != '0);
    assign full     = (count_q == FULL_COUNT);
    // When full, a release can only land if a grant frees a slot on the same edge.
    assign push     = push_req && (!full || grant);

    always_comb begin
        wr_en   = 1'b0;
        wr_data = fill_ptr_q;
        if (state_q == StInit) begin
            wr_en = 1'b1;
        end else if (push) begin
            wr_en   = 1'b1;
            wr_data = commited_wr_register;
        end
        if (reset) begin
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buffer[tail_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StInit;
            fill_ptr_q <= FILL_FIRST;
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    tail_ptr_q <= tail_ptr_q + 1'b1;
                    count_q    <= count_q + 1'b1;
                    fill_ptr_q <= fill_ptr_q + 1'b1;
                    if (fill_ptr_q == FILL_LAST) begin
                        state_q <= StReady;
                    end
                end
                StReady: begin
                    if (push) begin
                        tail_ptr_q <= tail_ptr_q + 1'b1;
                    end
                    if (grant) begin
                        head_ptr_q <= head_ptr_q + 1'b1;
                    end
                    if (push && !grant) begin
                        count_q <= count_q + 1'b1;
                    end else if (grant && !push) begin
                        count_q <= count_q - 1'b1;
                    end
                    if (push_req && full && !grant) begin
                        overflow_q <= 1'b1;
                    end
                end
                default: state_q <= StInit;
            endcase
        end
    end

    assign alloc_valid   = grant;
    assign alloc_reg_num = buffer[head_ptr_q];
    assign free_count    = count_q;
    assign init_done     = (state_q == StReady);
    assign overflow_err  = overflow_q;

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: stimulus queues expected grant numbers,
// a negedge monitor pops and compares them whenever the DUT grants.
module tb_phys_reg_free_list;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_req;
    logic       alloc_valid;
    logic [6:0] alloc_reg_num;
    logic       commit_valid;
    logic       commit_with_write;
    logic [6:0] commited_wr_register;
    logic [7:0] free_count;
    logic       init_done;
    logic       overflow_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_q[$];

    phys_reg_free_list dut (
        .clk                  (clk),
        .reset                (reset),
        .alloc_req            (alloc_req),
        .alloc_valid          (alloc_valid),
        .alloc_reg_num        (alloc_reg_num),
        .commit_valid         (commit_valid),
        .commit_with_write    (commit_with_write),
        .commited_wr_register (commited_wr_register),
        .free_count           (free_count),
        .init_done            (init_done),
        .overflow_err         (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every grant must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && alloc_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_grant: got reg %0d, expected no grant", alloc_reg_num);
            end else begin
                check("grant_reg", int'(alloc_reg_num), exp_q.pop_front());
            end
        end
    end

    task automatic tick(input logic req, input logic cv, input logic cw, input int r);
        alloc_req            = req;
        commit_valid         = cv;
        commit_with_write    = cw;
        commited_wr_register = 7'(r);
        @(posedge clk);
        #1;
    endtask

    // Counts edges after reset release until init_done; flags any grant seen during INIT.
    task automatic wait_init(output int n, output int bad);
        n   = -1;
        bad = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (init_done) begin
                alloc_req    = 1'b0;
                commit_valid = 1'b0;
                n = i;
                break;
            end
            if (alloc_valid) bad++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int bad;

        reset = 1'b1;
        alloc_req = 1'b0;
        commit_valid = 1'b0;
        commit_with_write = 1'b0;
        commited_wr_register = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_free_count", int'(free_count), 0);
        check("reset_init_done", int'(init_done), 0);
        check("reset_overflow", int'(overflow_err), 0);

        // Request and release throughout INIT; both must be ignored.
        alloc_req = 1'b1;
        commit_valid = 1'b1;
        commit_with_write = 1'b1;
        commited_wr_register = 7'd5;
        wait_init(n, bad);
        check("init_cycles", n, 96);
        check("init_alloc_valid_seen", bad, 0);
        check("init_free_count", int'(free_count), 96);

        for (int v = 32; v <= 35; v++) begin
            exp_q.push_back(v);
            tick(1'b1, 1'b0, 1'b0, 0);
        end
        check("after4_free_count", int'(free_count), 92);

        tick(1'b0, 1'b1, 1'b1, 0);
        check("release_reg0_count", int'(free_count), 92);
        tick(1'b0, 1'b1, 1'b0, 9);
        check("release_nowrite_count", int'(free_count), 92);

        for (int v = 36; v <= 77; v++) begin
            exp_q.push_back(v);
            tick(1'b1, 1'b0, 1'b0, 0);
        end
        check("drain_to_50", int'(free_count), 50);
        exp_q.push_back(78);
        tick(1'b1, 1'b1, 1'b1, 7);
        check("grant_release_count", int'(free_count), 50);

        for (int v = 79; v <= 127; v++) exp_q.push_back(v);
        exp_q.push_back(7);
        repeat (50) tick(1'b1, 1'b0, 1'b0, 0);
        check("drained_count", int'(free_count), 0);

        // Empty list: a release does not bypass to a same-cycle grant.
        alloc_req = 1'b1;
        commit_valid = 1'b1;
        commit_with_write = 1'b1;
        commited_wr_register = 7'd40;
        #1;
        check("empty_release_no_bypass", int'(alloc_valid), 0);
        @(posedge clk);
        #1;
        exp_q.push_back(40);
        tick(1'b1, 1'b0, 1'b0, 0);
        check("after_40_count", int'(free_count), 0);

        for (int i = 0; i < 128; i++) tick(1'b0, 1'b1, 1'b1, (i % 127) + 1);
        check("filled_count", int'(free_count), 128);
        check("filled_no_overflow", int'(overflow_err), 0);

        exp_q.push_back(1);
        tick(1'b1, 1'b1, 1'b1, 99);
        check("full_grant_release_count", int'(free_count), 128);
        check("full_grant_release_no_err", int'(overflow_err), 0);

        tick(1'b0, 1'b1, 1'b1, 55);
        check("overflow_set", int'(overflow_err), 1);
        check("overflow_count_held", int'(free_count), 128);
        tick(1'b0, 1'b0, 1'b0, 0);
        check("overflow_sticky", int'(overflow_err), 1);

        reset = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 0);
        reset = 1'b0;
        check("midrun_reset_overflow", int'(overflow_err), 0);
        check("midrun_reset_count", int'(free_count), 0);
        check("midrun_reset_init_done", int'(init_done), 0);

        wait_init(n, bad);
        check("reinit_cycles", n, 96);
        check("reinit_free_count", int'(free_count), 96);
        exp_q.push_back(32);
        tick(1'b1, 1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 1'b0, 0);
        tick(1'b0, 1'b0, 1'b0, 0);
        check("reinit_after_grant_count", int'(free_count), 95);
        check("pending_expected_grants", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
